// File: rtl/cp0_ctrl.sv
// CP0 register file and exception/interrupt sequencer for the WB stage.
// Latency: mfc0 data, flush and redirect are combinational in the WB cycle; state updates at the next edge.
// No backpressure: one WB instruction per cycle; flush kills the pipeline. Optional timer: CP0_TIMER_EN.
module cp0_ctrl #(
  parameter logic [31:0] EXC_ENTRY  = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [8:0]  wb_exception,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  input  logic        wb_bd,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic [5:0]  ext_int,
  output logic        c0_valid,
  output logic [31:0] c0_res,
  output logic        int_taken,
  output logic        flush,
  output logic [31:0] flush_pc
);

  localparam logic [4:0] R_BADV = 5'd8,  R_COUNT = 5'd9,  R_COMPARE = 5'd11;
  localparam logic [4:0] R_STATUS = 5'd12, R_CAUSE = 5'd13, R_EPC = 5'd14;

  // WB exception vector, MSB first: sys,mfc0,mtc0,eret,break,ov,adel,ades,ri
  logic ex_sys, ex_mfc0, ex_mtc0, ex_eret, ex_brk, ex_ov, ex_adel, ex_ades, ex_ri;
  assign {ex_sys, ex_mfc0, ex_mtc0, ex_eret, ex_brk, ex_ov, ex_adel, ex_ades, ex_ri} = wb_exception;

  logic [31:0] status_q, status_d, epc_q, epc_d, badv_q, badv_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic        ti;
  logic [31:0] count_rd, compare_rd, cause;
  logic        int_pending, sync_exc, exc_take, eret_take, mtc0_we;
  logic [4:0]  sel_code;

  assign cause = {bd_q, ti, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};

  // Reset wins over everything: no flush or interrupt is reported while it is held.
  assign int_pending = status_q[0] & ~status_q[1] & |({ip_hw_q, ip_sw_q} & status_q[15:8]);
  assign sync_exc    = ex_adel | ex_ri | ex_ov | ex_sys | ex_brk | ex_ades;
  assign int_taken   = wb_valid & ~reset & int_pending & ~ex_eret;
  assign exc_take    = wb_valid & ~reset & (int_taken | sync_exc);
  assign eret_take   = wb_valid & ~reset & ex_eret & ~exc_take;
  assign mtc0_we     = wb_valid & ~reset & ex_mtc0 & ~exc_take;

  assign flush    = exc_take | eret_take;
  assign flush_pc = exc_take ? EXC_ENTRY : epc_q;
  assign c0_valid = wb_valid & ex_mfc0;

  // Exception priority: interrupt, adel, ri, ov, sys, break, ades.
  always_comb begin
    if (int_taken)    sel_code = 5'd0;
    else if (ex_adel) sel_code = 5'd4;
    else if (ex_ri)   sel_code = 5'd10;
    else if (ex_ov)   sel_code = 5'd12;
    else if (ex_sys)  sel_code = 5'd8;
    else if (ex_brk)  sel_code = 5'd9;
    else              sel_code = 5'd5;
  end

  // mfc0 read mux; unmapped registers read zero.
  always_comb begin
    case (wb_addr)
      R_BADV:    c0_res = badv_q;
      R_COUNT:   c0_res = count_rd;
      R_COMPARE: c0_res = compare_rd;
      R_STATUS:  c0_res = status_q;
      R_CAUSE:   c0_res = cause;
      R_EPC:     c0_res = epc_q;
      default:   c0_res = 32'd0;
    endcase
  end

`ifdef CP0_TIMER_EN
  logic        tick_q, tick_d, ti_q, ti_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;

  // Timer next state: Count advances every other cycle, software writes win; TI is sticky until Compare is written.
  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q + {31'd0, tick_q};
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_q == compare_q && count_q != 32'd0) ti_d = 1'b1;
    if (mtc0_we && wb_addr == R_COUNT) count_d = wb_wdata;
    if (mtc0_we && wb_addr == R_COMPARE) begin
      compare_d = wb_wdata;
      ti_d      = 1'b0;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end
`else
  assign ti         = 1'b0;
  assign count_rd   = 32'd0;
  assign compare_rd = 32'd0;
`endif

  // Architectural next state: exception entry beats mtc0; eret only clears EXL.
  always_comb begin
    status_d  = status_q;
    epc_d     = epc_q;
    badv_d    = badv_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    ip_sw_d   = ip_sw_q;
    ip_hw_d   = {ext_int[5] | ti, ext_int[4:0]};
    if (mtc0_we) begin
      case (wb_addr)
        R_STATUS: status_d = (wb_wdata & 32'h0000_FF03) | (STATUS_RST & 32'h0040_0000);
        R_CAUSE:  ip_sw_d  = wb_wdata[9:8];
        R_EPC:    epc_d    = wb_wdata;
        default:  ;
      endcase
    end
    if (exc_take) begin
      status_d[1] = 1'b1;
      exccode_d   = sel_code;
      // A nested exception keeps the original return point.
      if (!status_q[1]) begin
        bd_d  = wb_bd;
        epc_d = wb_bd ? (wb_pc - 32'd4) : wb_pc;
      end
      if (sel_code == 5'd4 || sel_code == 5'd5) badv_d = wb_badvaddr;
    end else if (eret_take) begin
      status_d[1] = 1'b0;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q  <= STATUS_RST;
      epc_q     <= 32'd0;
      badv_q    <= 32'd0;
      bd_q      <= 1'b0;
      exccode_q <= 5'd0;
      ip_hw_q   <= 6'd0;
      ip_sw_q   <= 2'd0;
    end else begin
      status_q  <= status_d;
      epc_q     <= epc_d;
      badv_q    <= badv_d;
      bd_q      <= bd_d;
      exccode_q <= exccode_d;
      ip_hw_q   <= ip_hw_d;
      ip_sw_q   <= ip_sw_d;
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: expectations are queued per step and checked mid-cycle.
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
// Timer checks only apply when CP0_TIMER_EN is defined.
module tb_cp0_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic [8:0]  wb_exception = '0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_wdata = '0;
  logic        wb_bd = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_badvaddr = '0;
  logic [5:0]  ext_int = '0;
  logic        c0_valid, int_taken, flush;
  logic [31:0] c0_res, flush_pc;

  always #5 clk = ~clk;

  cp0_ctrl dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_exception(wb_exception),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_bd(wb_bd), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .ext_int(ext_int), .c0_valid(c0_valid), .c0_res(c0_res),
    .int_taken(int_taken), .flush(flush), .flush_pc(flush_pc)
  );

  localparam logic [8:0] E_SYS = 9'h100, E_MFC0 = 9'h080, E_MTC0 = 9'h040, E_ERET = 9'h020;
  localparam logic [8:0] E_BRK = 9'h010, E_OV = 9'h008, E_ADEL = 9'h004, E_RI = 9'h001;
  localparam int S_VLD = 0, S_RES = 1, S_INT = 2, S_FL = 3, S_FPC = 4;
  localparam logic [31:0] ENTRY = 32'hBFC0_0380;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_VLD:   return {31'd0, c0_valid};
      S_RES:   return c0_res;
      S_INT:   return {31'd0, int_taken};
      S_FL:    return {31'd0, flush};
      default: return flush_pc;
    endcase
  endfunction

  task automatic push(string tag, int sel, logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drive(logic v, logic [8:0] e, logic [4:0] a, logic [31:0] wd,
                       logic bd, logic [31:0] pc, logic [31:0] bv);
    @(negedge clk);
    wb_valid = v; wb_exception = e; wb_addr = a; wb_wdata = wd;
    wb_bd = bd; wb_pc = pc; wb_badvaddr = bv;
  endtask

  task automatic check_sb();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      n_tests++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 9'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rd(logic [4:0] a, logic [31:0] exp, string tag);
    drive(1'b1, E_MFC0, a, 32'd0, 1'b0, 32'd0, 32'd0);
    push({tag, "_vld"}, S_VLD, 32'd1);
    push(tag, S_RES, exp);
    push({tag, "_nofl"}, S_FL, 32'd0);
    check_sb();
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d, string tag);
    drive(1'b1, E_MTC0, a, d, 1'b0, 32'd0, 32'd0);
    push({tag, "_nofl"}, S_FL, 32'd0);
    push({tag, "_novld"}, S_VLD, 32'd0);
    check_sb();
  endtask

  // Instruction that must flush with the given redirect target.
  task automatic exc(logic [8:0] e, logic bd, logic [31:0] pc, logic [31:0] bv,
                     logic itk, logic [31:0] fpc, string tag);
    drive(1'b1, e, 5'd14, 32'hFFFF_0000, bd, pc, bv);
    push({tag, "_fl"}, S_FL, 32'd1);
    push({tag, "_fpc"}, S_FPC, fpc);
    push({tag, "_int"}, S_INT, {31'd0, itk});
    check_sb();
  endtask

  initial begin
    // Reset held: even a valid syscall must not flush.
    idle();
    idle();
    drive(1'b1, E_SYS, 5'd0, 32'd0, 1'b0, 32'h100, 32'd0);
    push("rst_nofl", S_FL, 32'd0);
    push("rst_noint", S_INT, 32'd0);
    check_sb();
    idle();
    reset = 1'b0;
    push("idle_novld", S_VLD, 32'd0);
    push("idle_nofl", S_FL, 32'd0);
    check_sb();

    rd(5'd12, 32'h0040_0000, "rst_status");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");

    // syscall, not in a delay slot
    exc(E_SYS, 1'b0, 32'hBFC0_1000, 32'd0, 1'b0, ENTRY, "sys");
    rd(5'd14, 32'hBFC0_1000, "sys_epc");
    rd(5'd13, 32'h0000_0020, "sys_cause");
    rd(5'd12, 32'h0040_0002, "sys_status");
    exc(E_ERET, 1'b0, 32'h0, 32'd0, 1'b0, 32'hBFC0_1000, "eret1");
    rd(5'd12, 32'h0040_0000, "eret1_status");

    // adel in a delay slot
    exc(E_ADEL, 1'b1, 32'h8000_0104, 32'h0000_0003, 1'b0, ENTRY, "adel");
    rd(5'd14, 32'h8000_0100, "adel_epc");
    rd(5'd13, 32'h8000_0010, "adel_cause");
    rd(5'd8, 32'h0000_0003, "adel_badv");
    exc(E_ERET, 1'b0, 32'h0, 32'd0, 1'b0, 32'h8000_0100, "eret2");
    rd(5'd12, 32'h0040_0000, "eret2_status");

    // nested exception keeps EPC/BD
    exc(E_OV, 1'b0, 32'h9000_0000, 32'd0, 1'b0, ENTRY, "ov");
    rd(5'd13, 32'h0000_0030, "ov_cause");
    exc(E_RI, 1'b1, 32'hA000_0004, 32'd0, 1'b0, ENTRY, "nested_ri");
    rd(5'd14, 32'h9000_0000, "nested_epc");
    rd(5'd13, 32'h0000_0028, "nested_cause");
    exc(E_ERET, 1'b0, 32'h0, 32'd0, 1'b0, 32'h9000_0000, "eret3");

    // eret co-flagged with ri: exception wins
    exc(E_ERET | E_RI, 1'b0, 32'h0000_0100, 32'd0, 1'b0, ENTRY, "eret_ri");
    rd(5'd14, 32'h0000_0100, "eret_ri_epc");
    rd(5'd12, 32'h0040_0002, "eret_ri_status");
    exc(E_ERET, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0000_0100, "eret4");

    // ri + ov with a discarded mtc0 to EPC
    exc(E_RI | E_OV | E_MTC0, 1'b0, 32'h0000_0200, 32'd0, 1'b0, ENTRY, "ri_ov");
    rd(5'd13, 32'h0000_0028, "ri_ov_cause");
    rd(5'd14, 32'h0000_0200, "ri_ov_epc");
    exc(E_ERET, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0000_0200, "eret5");

    // external interrupt beats ri
    wr(5'd12, 32'h0000_0401, "wr_status_im10");
    ext_int = 6'b000001;
    idle();
    push("int_idle_noint", S_INT, 32'd0);
    push("int_idle_nofl", S_FL, 32'd0);
    check_sb();
    exc(E_RI, 1'b0, 32'h0000_0300, 32'd0, 1'b1, ENTRY, "int_ri");
    ext_int = 6'b000000;
    rd(5'd13, 32'h0000_0000, "int_cause");
    rd(5'd14, 32'h0000_0300, "int_epc");
    rd(5'd12, 32'h0040_0403, "int_status");
    wr(5'd13, 32'hFFFF_FFFF, "wr_cause");
    rd(5'd13, 32'h0000_0300, "cause_sw_ip");
    wr(5'd13, 32'h0, "clr_cause");
    exc(E_ERET, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0000_0300, "eret6");

    // unmapped register
    wr(5'd5, 32'hDEAD_BEEF, "wr_unmapped");
    rd(5'd5, 32'h0, "rd_unmapped");

`ifdef CP0_TIMER_EN
    begin
      bit found;
      found = 1'b0;
      wr(5'd12, 32'h0, "tmr_status_off");
      wr(5'd11, 32'd5, "tmr_compare");
      wr(5'd9, 32'd0, "tmr_count");
      wr(5'd12, 32'h0000_8001, "tmr_status_on");
      for (int i = 0; i < 40 && !found; i++) begin
        drive(1'b0, 9'd0, 5'd13, 32'd0, 1'b0, 32'd0, 32'd0);
        #1;
        found = c0_res[30];
      end
      n_tests++;
      assert (found) else begin
        n_fail++;
        $error("FAIL tmr_ti_seen: observed %0d expected %0d", found, 1);
      end
      wb_addr = 5'd9;
      push("tmr_count_at_ti", S_RES, 32'd5);
      check_sb();
      idle();
      exc(9'd0, 1'b0, 32'h0000_0500, 32'd0, 1'b1, ENTRY, "tmr_int");
      rd(5'd13, 32'h4000_8000, "tmr_cause");
      wr(5'd11, 32'd1000, "tmr_clr");
      rd(5'd13, 32'h0000_8000, "tmr_ti_clr");
      rd(5'd13, 32'h0000_0000, "tmr_ip_clr");
    end
`else
    wr(5'd9, 32'd7, "wr_count");
    rd(5'd9, 32'h0, "count_off");
    wr(5'd11, 32'd5, "wr_compare");
    rd(5'd11, 32'h0, "compare_off");
`endif

    // reset while in an exception
    exc(E_BRK, 1'b0, 32'h0000_0400, 32'd0, 1'b0, ENTRY, "brk");
    reset = 1'b1;
    drive(1'b1, E_SYS, 5'd0, 32'd0, 1'b0, 32'h0000_0600, 32'd0);
    push("midrst_nofl", S_FL, 32'd0);
    push("midrst_noint", S_INT, 32'd0);
    check_sb();
    idle();
    reset = 1'b0;
    rd(5'd12, 32'h0040_0000, "midrst_status");
    rd(5'd13, 32'h0, "midrst_cause");
    rd(5'd14, 32'h0, "midrst_epc");
    rd(5'd8, 32'h0, "midrst_badv");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
